// File: rtl/fas_serial_ctrl_if.sv
// Requester-side bundle for fas_serial_ctrl: operation request in, result/status out.
interface fas_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_add;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (output start, op_add, op_a, op_b,
                    input  busy, done, result, carry_out);
    modport slave  (input  start, op_add, op_a, op_b,
                    output busy, done, result, carry_out);
endinterface

// File: rtl/fas_serial_ctrl.sv
// Bit-serial add/sub sequencer driving one external 1-bit full adder/subtractor LSB-first.
// Optional macro FAS_SERIAL_OVF_EN adds a registered signed-overflow output.
module fas_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    fas_serial_ctrl_if.slave   req,
    output logic               fas_a,
    output logic               fas_b,
    output logic               fas_cin,
    output logic               fas_a_ns,
    input  logic               fas_s,
    input  logic               fas_cout
`ifdef FAS_SERIAL_OVF_EN
    ,
    output logic               overflow
`endif
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_sh, b_sh, result_q;
    logic [IDX_W-1:0]   idx;
    logic               carry_q, op_add_q, carry_out_q;
    logic               accept, last_bit;

    // start is only honoured outside RUN; requests while busy are dropped
    assign accept   = req.start && (state != RUN);
    assign last_bit = (state == RUN) && (idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req.start) state_nx = RUN;
            RUN:     if (last_bit)  state_nx = DONE;
            DONE:    state_nx = req.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req.busy  = (state == RUN);
        req.done  = (state == DONE);
        fas_a     = 1'b0;
        fas_b     = 1'b0;
        fas_cin   = 1'b0;
        fas_a_ns  = op_add_q;
        if (state == RUN) begin
            fas_a   = a_sh[0];
            fas_b   = b_sh[0];
            fas_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh        <= '0;
            b_sh        <= '0;
            idx         <= '0;
            carry_q     <= 1'b0;
            op_add_q    <= 1'b1;
            result_q    <= '0;
            carry_out_q <= 1'b0;
`ifdef FAS_SERIAL_OVF_EN
            overflow    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh     <= req.op_a;
            b_sh     <= req.op_b;
            op_add_q <= req.op_add;
            idx      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else if (state == RUN) begin
            result_q[idx] <= fas_s;
            carry_q       <= fas_cout;
            a_sh          <= a_sh >> 1;
            b_sh          <= b_sh >> 1;
            idx           <= idx + IDX_W'(1);
            if (last_bit) begin
                carry_out_q <= fas_cout;
`ifdef FAS_SERIAL_OVF_EN
                // carry_q holds the carry into the MSB during the last bit
                overflow    <= carry_q ^ fas_cout;
`endif
            end
        end
    end

    assign req.result    = result_q;
    assign req.carry_out = carry_out_q;
endmodule
